// File: rtl/freq_meter.sv
// Gated edge counter: counts sig_in edges over GATE_CYCLES clocks, saturating at 2^CNT_W-1.
// Define FREQ_METER_DUAL_EDGE_EN to count both rising and falling edges.
module freq_meter #(
    parameter int GATE_CYCLES = 1024,
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             sig_in,
    input  logic             start,
    input  logic             cont,
    output logic             busy,
    output logic             valid,
    output logic [CNT_W-1:0] result,
    output logic             ovf
);

    localparam int               TW    = $clog2(GATE_CYCLES);
    localparam logic [TW-1:0]    TLOAD = TW'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CMAX  = '1;

    typedef enum logic [1:0] {IDLE, GATE, DONE} state_t;

    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] sync_p0;
    logic                   dly_p1;
    logic                   edge_p;
    logic [CNT_W-1:0]       cnt;
    logic                   ovf_int;
    logic [TW-1:0]          timer;
    logic                   load;
    logic                   publish;
    logic [CNT_W-1:0]       cnt_inc;
    logic                   sat_hit;

    // Saturating increment: returns {hit_ceiling, next_count}.
    function automatic logic [CNT_W:0] sat_inc(input logic [CNT_W-1:0] c);
        if (c == CMAX) begin
            return {1'b1, c};
        end
        return {1'b0, c + CNT_W'(1)};
    endfunction

    // Stage p0: synchronizer chain, index 0 is the newest sample
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_p0 <= '0;
            dly_p1  <= 1'b0;
        end else begin
            sync_p0 <= {sync_p0[SYNC_STAGES-2:0], sig_in};
            dly_p1  <= sync_p0[SYNC_STAGES-1];
        end
    end

    // Stage p1: edge detect against the one-cycle delayed copy
`ifdef FREQ_METER_DUAL_EDGE_EN
    assign edge_p = sync_p0[SYNC_STAGES-1] ^ dly_p1;
`else
    assign edge_p = sync_p0[SYNC_STAGES-1] & ~dly_p1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (ena && (start || cont)) state_nxt = GATE;
            GATE: begin
                if (!ena) begin
                    state_nxt = IDLE;
                end else if (timer == '0) begin
                    state_nxt = DONE;
                end
            end
            DONE: state_nxt = (ena && cont) ? GATE : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign load    = (state != GATE) && (state_nxt == GATE);
    assign publish = (state == DONE) && ena;
    assign busy    = (state != IDLE);
    assign {sat_hit, cnt_inc} = sat_inc(cnt);

    // Stage p2: window counter, timer and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            ovf_int <= 1'b0;
            timer   <= '0;
            result  <= '0;
            ovf     <= 1'b0;
            valid   <= 1'b0;
        end else begin
            valid <= publish;
            if (load) begin
                cnt     <= '0;
                ovf_int <= 1'b0;
                timer   <= TLOAD;
            end else if (state == GATE && ena) begin
                timer <= timer - TW'(1);
                if (edge_p) begin
                    cnt     <= cnt_inc;
                    ovf_int <= ovf_int | sat_hit;
                end
            end
            if (publish) begin
                result <= cnt;
                ovf    <= ovf_int;
            end
        end
    end

endmodule
